mult_sequencer: RTL and testbench

Control unit for the 8-bit signed add-shift multiplier datapath (registers X, A, B; 9-bit adder/subtractor). It turns the operator's RUN and CLEARA_LOADB button inputs into per-cycle datapath commands. One run has a clear step, N add/subtract steps and N shift steps. The datapath feeds back M, the current LSB of B, and the sequencer decides from it whether each step adds, subtracts or skips. The block sits between the debounced button inputs and the register/adder control pins inside the multiplier top level.

---
 rtl/mult_sequencer.sv | 119 +++++++++++
 tb/tb_mult_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_sequencer.sv
// Sequencer for the 8-bit signed add-shift multiplier: turns the RUN and CLEARA_LOADB
// buttons into per-cycle clear/load/add/sub/shift commands for the X/A/B datapath.
module mult_sequencer #(
  parameter int N = 8
) (
  input  logic CLK,
  input  logic RESET,
  input  logic RUN,
  input  logic CLEARA_LOADB,
  input  logic M,
  output logic clr_ax,
  output logic ld_b,
  output logic add,
  output logic sub,
  output logic shift,
  output logic busy,
  output logic done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLRA  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  // Registered copy of the load request so clear/load follow the button one cycle late.
  logic          load_reg, load_next;
  logic          last_step;

  assign last_step = (cnt_reg == LAST);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      load_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      load_reg  <= load_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    load_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!RUN) begin
          state_next = CLRA;
          cnt_next   = '0;
        end else begin
          load_next = !CLEARA_LOADB;
        end
      end
      CLRA: state_next = ADD;
      ADD:  state_next = SHIFT;
      SHIFT: begin
        if (last_step) begin
          state_next = HOLD;
        end else begin
          cnt_next   = cnt_reg + 1'b1;
          state_next = ADD;
        end
      end
      // Waiting for RUN release keeps a held button from starting a second run.
      HOLD: begin
        if (RUN) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    clr_ax = 1'b0;
    ld_b   = 1'b0;
    add    = 1'b0;
    sub    = 1'b0;
    shift  = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_reg)
      IDLE: begin
        clr_ax = load_reg;
        ld_b   = load_reg;
      end
      CLRA: begin
        clr_ax = 1'b1;
        busy   = 1'b1;
      end
      ADD: begin
        busy = 1'b1;
        // The top multiplier bit carries negative weight, so its step subtracts.
        if (M) begin
          if (last_step) sub = 1'b1;
          else           add = 1'b1;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        busy  = 1'b1;
      end
      HOLD: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_sequencer.sv
// Directed bench for mult_sequencer with a small X/A/B datapath model closing the M loop.
module tb_mult_sequencer;

  localparam int N = 8;

  logic CLK = 1'b0;
  logic RESET, RUN, CLEARA_LOADB, M;
  logic clr_ax, ld_b, add, sub, shift, busy, done;
  logic [6:0] outs;

  logic [7:0] sw = 8'h00;
  logic [7:0] a_reg = 8'h00;
  logic [7:0] b_reg = 8'h00;
  logic       x_reg = 1'b0;
  logic [8:0] sum_add, sum_sub;

  int checks = 0;
  int errors = 0;

  mult_sequencer #(.N(N)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .RUN          (RUN),
    .CLEARA_LOADB (CLEARA_LOADB),
    .M            (M),
    .clr_ax       (clr_ax),
    .ld_b         (ld_b),
    .add          (add),
    .sub          (sub),
    .shift        (shift),
    .busy         (busy),
    .done         (done)
  );

  always #5 CLK = ~CLK;

  assign outs    = {clr_ax, ld_b, add, sub, shift, busy, done};
  assign M       = b_reg[0];
  assign sum_add = {a_reg[7], a_reg} + {sw[7], sw};
  assign sum_sub = {a_reg[7], a_reg} - {sw[7], sw};

  // Datapath model: registers X, A, B driven by the sequencer commands.
  always @(posedge CLK) begin
    if (clr_ax) begin
      a_reg <= 8'h00;
      x_reg <= 1'b0;
    end
    if (ld_b)  b_reg <= sw;
    if (add)   {x_reg, a_reg} <= sum_add;
    if (sub)   {x_reg, a_reg} <= sum_sub;
    if (shift) begin
      a_reg <= {x_reg, a_reg[7:1]};
      b_reg <= {a_reg[0], b_reg[7:1]};
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Full run from IDLE; RUN is left low so the caller decides when to release it.
  task automatic do_run(input string tag, input logic [7:0] add_mask, input logic [7:0] sub_mask);
    RUN = 1'b0;
    tick();
    check({tag, " clra"}, 32'(outs), 32'(7'b1000010));
    for (int i = 0; i < N; i++) begin
      tick();
      check($sformatf("%s add_step%0d", tag, i), 32'(outs),
            32'({2'b00, add_mask[i], sub_mask[i], 1'b0, 1'b1, 1'b0}));
      tick();
      check($sformatf("%s shift_step%0d", tag, i), 32'(outs), 32'(7'b0000110));
    end
    tick();
    check({tag, " done"}, 32'(outs), 32'(7'b0000001));
    $display("run %s: A:B=0x%02h%02h", tag, a_reg, b_reg);
  endtask

  initial begin
    int clr_n, shift_n, done_n, busy_n, ld_n, guard;

    RESET = 1'b0;
    RUN = 1'b0;
    CLEARA_LOADB = 1'b0;
    tick();
    check("reset_held_0", 32'(outs), 32'd0);
    tick();
    check("reset_held_1", 32'(outs), 32'd0);
    RESET = 1'b1;
    RUN = 1'b1;
    CLEARA_LOADB = 1'b1;
    tick();
    check("after_reset_idle", 32'(outs), 32'd0);

    // Load B = 11 for three cycles
    sw = 8'h0B;
    CLEARA_LOADB = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("load_cycle%0d", i), 32'(outs), 32'(7'b1100000));
    end
    CLEARA_LOADB = 1'b1;
    tick();
    check("load_release", 32'(outs), 32'd0);
    check("load_b_value", 32'(b_reg), 32'h0B);
    $display("load: B=0x%02h", b_reg);

    // 11 * -3 = -33
    sw = 8'hFD;
    do_run("b11_sm3", 8'b0000_1011, 8'b0000_0000);
    check("b11_sm3 product", 32'({a_reg, b_reg}), 32'hFFDF);
    RUN = 1'b1;
    tick();
    check("b11_sm3 release_idle", 32'(outs), 32'd0);

    // -1 * 1 = -1
    sw = 8'hFF;
    CLEARA_LOADB = 1'b0;
    tick();
    check("load_ff", 32'(outs), 32'(7'b1100000));
    CLEARA_LOADB = 1'b1;
    tick();
    check("load_ff_release", 32'(outs), 32'd0);
    sw = 8'h01;
    do_run("bm1_s1", 8'b0111_1111, 8'b1000_0000);
    check("bm1_s1 product", 32'({a_reg, b_reg}), 32'hFFFF);
    RUN = 1'b1;
    tick();
    check("bm1_s1 release_idle", 32'(outs), 32'd0);

    // RUN held low for 40 cycles gives exactly one run
    clr_n = 0; shift_n = 0; done_n = 0; busy_n = 0; ld_n = 0;
    RUN = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      clr_n   += int'(clr_ax);
      shift_n += int'(shift);
      done_n  += int'(done);
      busy_n  += int'(busy);
      ld_n    += int'(ld_b);
    end
    $display("held_run: clr=%0d shift=%0d done=%0d busy=%0d ld=%0d", clr_n, shift_n, done_n, busy_n, ld_n);
    check("held clr_count", 32'(clr_n), 32'd1);
    check("held shift_count", 32'(shift_n), 32'd8);
    check("held done_count", 32'(done_n), 32'd23);
    check("held busy_count", 32'(busy_n), 32'd17);
    check("held ld_count", 32'(ld_n), 32'd0);
    check("held still_done", 32'(outs), 32'(7'b0000001));
    RUN = 1'b1;
    tick();
    check("held release_idle", 32'(outs), 32'd0);

    // Second press, then reset during SHIFT with cnt=3
    RUN = 1'b0;
    tick();
    check("repress clra", 32'(outs), 32'(7'b1000010));
    tick();
    check("repress single_clr", 32'(clr_ax), 32'd0);
    for (int i = 0; i < 7; i++) tick();
    check("mid_shift_cnt3", 32'({shift, busy}), 32'(2'b11));
    RESET = 1'b0;
    #1;
    check("async_reset_outputs", 32'(outs), 32'd0);
    tick();
    check("reset_hold_outputs", 32'(outs), 32'd0);
    RESET = 1'b1;
    RUN = 1'b1;
    tick();
    check("post_reset_idle", 32'(outs), 32'd0);

    // Both buttons low in IDLE: run wins, no load
    RUN = 1'b0;
    CLEARA_LOADB = 1'b0;
    tick();
    check("priority clra_no_ld", 32'(outs), 32'(7'b1000010));
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("ignore_load_busy%0d", i), 32'({clr_ax, ld_b, busy}), 32'(3'b001));
    end
    CLEARA_LOADB = 1'b1;
    guard = 0;
    while (!done && guard < 30) begin
      tick();
      guard++;
    end
    check("priority run_done", 32'(done), 32'd1);
    RUN = 1'b1;
    tick();
    check("priority release_idle", 32'(outs), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
